parking_lot_arbiter: RTL and testbench

- Sequences the shared occupancy counter and the entry barriers for a parking lot with N_ENTRY entry lanes and one exit lane.
- Each lane's sensor FSM raises a request once it has decoded a complete car passage. This block serialises those requests, admits or denies entries against CAPACITY, and drives each lane's barrier-open timer.
- It is the single owner of the lot count; lane FSMs hold no count of their own.

---
 rtl/parking_lot_arbiter.sv | 193 +++++++++++++++++++
 tb/tb_parking_lot_arbiter.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/parking_lot_arbiter.sv
// parking_lot_arbiter
//   Serialises entry/exit requests for a parking lot, owns the occupancy
//   count, admits or denies entries against CAPACITY and drives the
//   per-lane barrier-open timer.
//
// Ports:
//   clk            system clock, rising edge
//   reset          synchronous active-low reset
//   entry_req      level request per entry lane (held until ack/deny)
//   exit_req       level request from the exit lane (held until ack/err)
//   entry_ack      1-cycle pulse, entry admitted
//   entry_deny     1-cycle pulse, lot full, entry refused
//   exit_ack       1-cycle pulse, exit accepted, count decremented
//   exit_err       1-cycle pulse, exit requested with an empty lot
//   gate_open      barrier open, at most one lane at a time
//   count          current occupancy
//   full / empty   count==CAPACITY / count==0
//   busy           FSM not idle
//
// Optional feature (macro PARK_STATS_EN):
//   entries_total  saturating count of entry_ack pulses
//   denies_total   saturating count of entry_deny pulses
module parking_lot_arbiter #(
   parameter int unsigned N_ENTRY   = 2,
   parameter int unsigned CAPACITY  = 15,
   parameter int unsigned CNT_W     = 4,
   parameter int unsigned GATE_HOLD = 8
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [N_ENTRY-1:0] entry_req,
   input  logic               exit_req,
   output logic [N_ENTRY-1:0] entry_ack,
   output logic [N_ENTRY-1:0] entry_deny,
   output logic               exit_ack,
   output logic               exit_err,
   output logic [N_ENTRY-1:0] gate_open,
   output logic [CNT_W-1:0]   count,
   output logic               full,
   output logic               empty,
`ifdef PARK_STATS_EN
   output logic [15:0]        entries_total,
   output logic [15:0]        denies_total,
`endif
   output logic               busy
);

   localparam int unsigned PTR_W = (N_ENTRY > 1) ? $clog2(N_ENTRY) : 1;
   localparam int unsigned TMR_W = (GATE_HOLD > 1) ? $clog2(GATE_HOLD) : 1;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_GATE = 2'd1,
      S_COOL = 2'd2
   } state_t;

   state_t             r_state;
   logic [PTR_W-1:0]   r_ptr;
   logic [TMR_W-1:0]   r_timer;
   logic [CNT_W-1:0]   r_count;
   logic               r_full;
   logic               r_empty;
   logic               r_busy;
   logic [N_ENTRY-1:0] r_entry_ack;
   logic [N_ENTRY-1:0] r_entry_deny;
   logic               r_exit_ack;
   logic               r_exit_err;
   logic [N_ENTRY-1:0] r_gate_open;
`ifdef PARK_STATS_EN
   logic [15:0]        r_entries_total;
   logic [15:0]        r_denies_total;
`endif

   logic               w_grant_vld;
   logic [PTR_W-1:0]   w_grant_idx;
   logic [PTR_W-1:0]   w_ptr_next;

   // Round-robin search: first requesting lane at or above the pointer, wrapping.
   always_comb begin
      int unsigned idx;
      idx         = 0;
      w_grant_vld = 1'b0;
      w_grant_idx = '0;
      for (int unsigned k = 0; k < N_ENTRY; k++) begin
         idx = (32'(r_ptr) + k) % N_ENTRY;
         if (!w_grant_vld && entry_req[PTR_W'(idx)]) begin
            w_grant_vld = 1'b1;
            w_grant_idx = PTR_W'(idx);
         end
      end
      w_ptr_next = PTR_W'((32'(w_grant_idx) + 32'd1) % N_ENTRY);
   end

   // Transaction FSM; owns the count and all response outputs.
   always_ff @(posedge clk) begin
      if (!reset) begin
         r_state      <= S_IDLE;
         r_ptr        <= '0;
         r_timer      <= '0;
         r_count      <= '0;
         r_full       <= 1'b0;
         r_empty      <= 1'b1;
         r_busy       <= 1'b0;
         r_entry_ack  <= '0;
         r_entry_deny <= '0;
         r_exit_ack   <= 1'b0;
         r_exit_err   <= 1'b0;
         r_gate_open  <= '0;
`ifdef PARK_STATS_EN
         r_entries_total <= '0;
         r_denies_total  <= '0;
`endif
      end else begin
         r_entry_ack  <= '0;
         r_entry_deny <= '0;
         r_exit_ack   <= 1'b0;
         r_exit_err   <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (exit_req) begin
                  // Exit always wins; an empty lot reports an error instead.
                  if (r_count != '0) begin
                     r_count    <= r_count - CNT_W'(1);
                     r_full     <= 1'b0;
                     r_empty    <= (r_count == CNT_W'(1));
                     r_exit_ack <= 1'b1;
                  end else begin
                     r_exit_err <= 1'b1;
                  end
                  r_state <= S_COOL;
                  r_busy  <= 1'b1;
               end else if (w_grant_vld) begin
                  r_ptr  <= w_ptr_next;
                  r_busy <= 1'b1;
                  if (r_count < CNT_W'(CAPACITY)) begin
                     r_count     <= r_count + CNT_W'(1);
                     r_full      <= ((r_count + CNT_W'(1)) == CNT_W'(CAPACITY));
                     r_empty     <= 1'b0;
                     r_entry_ack <= N_ENTRY'(1) << w_grant_idx;
                     r_gate_open <= N_ENTRY'(1) << w_grant_idx;
                     // Timer expires at zero, giving GATE_HOLD open cycles.
                     r_timer     <= TMR_W'(GATE_HOLD - 1);
                     r_state     <= S_GATE;
`ifdef PARK_STATS_EN
                     if (r_entries_total != 16'hFFFF)
                        r_entries_total <= r_entries_total + 16'd1;
`endif
                  end else begin
                     r_entry_deny <= N_ENTRY'(1) << w_grant_idx;
                     r_state      <= S_COOL;
`ifdef PARK_STATS_EN
                     if (r_denies_total != 16'hFFFF)
                        r_denies_total <= r_denies_total + 16'd1;
`endif
                  end
               end
            end
            S_GATE: begin
               if (r_timer == '0) begin
                  r_gate_open <= '0;
                  r_state     <= S_COOL;
               end else begin
                  r_timer <= r_timer - TMR_W'(1);
               end
            end
            S_COOL: begin
               r_state <= S_IDLE;
               r_busy  <= 1'b0;
            end
            default: begin
               r_state     <= S_IDLE;
               r_busy      <= 1'b0;
               r_gate_open <= '0;
            end
         endcase
      end
   end

   assign entry_ack  = r_entry_ack;
   assign entry_deny = r_entry_deny;
   assign exit_ack   = r_exit_ack;
   assign exit_err   = r_exit_err;
   assign gate_open  = r_gate_open;
   assign count      = r_count;
   assign full       = r_full;
   assign empty      = r_empty;
   assign busy       = r_busy;
`ifdef PARK_STATS_EN
   assign entries_total = r_entries_total;
   assign denies_total  = r_denies_total;
`endif

endmodule

// File: tb/tb_parking_lot_arbiter.sv
// tb_parking_lot_arbiter
//   Directed bench for parking_lot_arbiter at default parameters
//   (2 lanes, capacity 15, 4-bit count, gate hold 8).
module tb_parking_lot_arbiter;

   logic       clk;
   logic       reset;
   logic [1:0] entry_req;
   logic       exit_req;
   logic [1:0] entry_ack;
   logic [1:0] entry_deny;
   logic       exit_ack;
   logic       exit_err;
   logic [1:0] gate_open;
   logic [3:0] count;
   logic       full;
   logic       empty;
   logic       busy;
`ifdef PARK_STATS_EN
   logic [15:0] entries_total;
   logic [15:0] denies_total;
`endif

   int checks   = 0;
   int failures = 0;

   parking_lot_arbiter dut (
      .clk        (clk),
      .reset      (reset),
      .entry_req  (entry_req),
      .exit_req   (exit_req),
      .entry_ack  (entry_ack),
      .entry_deny (entry_deny),
      .exit_ack   (exit_ack),
      .exit_err   (exit_err),
      .gate_open  (gate_open),
      .count      (count),
      .full       (full),
      .empty      (empty),
`ifdef PARK_STATS_EN
      .entries_total (entries_total),
      .denies_total  (denies_total),
`endif
      .busy       (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Advance one rising edge; sample/drive 1 time unit after it.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_idle(input string tag);
      int n;
      n = 0;
      while (busy !== 1'b0 && n < 40) begin
         step();
         n++;
      end
      check(tag, 32'(busy), 32'd0);
   endtask

   task automatic do_entry(input int lane, input string tag);
      int n;
      n = 0;
      entry_req = 2'(1 << lane);
      step();
      while ((entry_ack | entry_deny) == 2'b00 && n < 40) begin
         step();
         n++;
      end
      check(tag, 32'(entry_ack), 32'(1 << lane));
      entry_req = 2'b00;
      wait_idle({tag, "_idle"});
   endtask

   task automatic do_exit(input string tag);
      int n;
      n = 0;
      exit_req = 1'b1;
      step();
      while (exit_ack === 1'b0 && exit_err === 1'b0 && n < 40) begin
         step();
         n++;
      end
      check(tag, 32'(exit_ack), 32'd1);
      exit_req = 1'b0;
      wait_idle({tag, "_idle"});
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog timeout checks=%0d failures=%0d", checks, failures);
      $fatal(1, "watchdog");
   end

   initial begin
      int ack_lane [4];
      int ack_cyc  [4];
      int nack;

      reset     = 1'b0;
      entry_req = 2'b00;
      exit_req  = 1'b0;
      step();
      step();

      // Reset state
      check("rst_count", 32'(count), 32'd0);
      check("rst_empty", 32'(empty), 32'd1);
      check("rst_full",  32'(full),  32'd0);
      check("rst_busy",  32'(busy),  32'd0);
      check("rst_gate",  32'(gate_open), 32'd0);
      check("rst_pulses", {26'd0, entry_ack, entry_deny, exit_ack, exit_err}, 32'd0);
      reset = 1'b1;
      step();

      // Single entry on lane 0: ack after one edge, gate 8 cycles, 1 cool cycle
      entry_req = 2'b01;
      step();
      check("e0_ack",   32'(entry_ack), 32'd1);
      check("e0_count", 32'(count), 32'd1);
      check("e0_empty", 32'(empty), 32'd0);
      check("e0_busy",  32'(busy), 32'd1);
      check("e0_gate0", 32'(gate_open), 32'd1);
      entry_req = 2'b00;
      for (int i = 1; i < 8; i++) begin
         step();
         check($sformatf("e0_gate%0d", i), 32'(gate_open), 32'd1);
         check($sformatf("e0_ackpulse%0d", i), 32'(entry_ack), 32'd0);
      end
      step();
      check("e0_gate_closed", 32'(gate_open), 32'd0);
      check("e0_cool_busy",   32'(busy), 32'd1);
      step();
      check("e0_idle", 32'(busy), 32'd0);

      // Fill to capacity via alternating lanes (pointer now at lane 1)
      for (int k = 0; k < 14; k++)
         do_entry((k % 2 == 0) ? 1 : 0, $sformatf("fill%0d", k));
      check("fill_count", 32'(count), 32'd15);
      check("fill_full",  32'(full), 32'd1);

      // One more on lane 1: denied
      entry_req = 2'b10;
      step();
      check("deny_pulse", 32'(entry_deny), 32'b10);
      check("deny_ack",   32'(entry_ack), 32'd0);
      check("deny_count", 32'(count), 32'd15);
      check("deny_full",  32'(full), 32'd1);
      check("deny_gate",  32'(gate_open), 32'd0);
      entry_req = 2'b00;
      step();
      check("deny_cool_gate", 32'(gate_open), 32'd0);
      check("deny_single_pulse", 32'(entry_deny), 32'd0);
      step();
      check("deny_idle", 32'(busy), 32'd0);

      // Exit and entry together at full: exit first
      exit_req  = 1'b1;
      entry_req = 2'b01;
      step();
      check("prio_exit_ack", 32'(exit_ack), 32'd1);
      check("prio_no_entry", 32'(entry_ack), 32'd0);
      check("prio_count14",  32'(count), 32'd14);
      check("prio_not_full", 32'(full), 32'd0);
      exit_req = 1'b0;
      step();
      check("prio_cool_no_ack", 32'(entry_ack), 32'd0);
      step();
      check("prio_entry_ack", 32'(entry_ack), 32'b01);
      check("prio_count15",   32'(count), 32'd15);
      check("prio_full",      32'(full), 32'd1);
      entry_req = 2'b00;
      wait_idle("prio_idle");
`ifdef PARK_STATS_EN
      check("stats_entries", 32'(entries_total), 32'd16);
      check("stats_denies",  32'(denies_total),  32'd1);
`endif

      // Drain to empty
      for (int k = 0; k < 15; k++)
         do_exit($sformatf("drain%0d", k));
      check("drain_count", 32'(count), 32'd0);
      check("drain_empty", 32'(empty), 32'd1);

      // Exit on empty lot: error pulse, count unchanged
      exit_req = 1'b1;
      step();
      check("xerr_pulse", 32'(exit_err), 32'd1);
      check("xerr_ack",   32'(exit_ack), 32'd0);
      check("xerr_count", 32'(count), 32'd0);
      check("xerr_empty", 32'(empty), 32'd1);
      exit_req = 1'b0;
      wait_idle("xerr_idle");

      // Reset to restore pointer, then both lanes held continuously
      reset = 1'b0;
      step();
      reset = 1'b1;
      entry_req = 2'b11;
      nack = 0;
      for (int c = 1; c <= 31; c++) begin
         step();
         if (entry_ack != 2'b00 && nack < 4) begin
            ack_lane[nack] = (entry_ack == 2'b10) ? 1 : 0;
            ack_cyc[nack]  = c;
            nack++;
         end
      end
      entry_req = 2'b00;
      check("rr_nack", 32'(nack), 32'd4);
      for (int j = 0; j < 4; j++) begin
         if (j < nack) begin
            check($sformatf("rr_lane%0d", j), 32'(ack_lane[j]), 32'(j % 2));
            check($sformatf("rr_cyc%0d", j),  32'(ack_cyc[j]),  32'(1 + 10 * j));
         end
      end
      wait_idle("rr_idle");
      check("rr_count", 32'(count), 32'd4);

      // Reset in the third GATE cycle aborts the transaction
      entry_req = 2'b01;
      step();
      check("abort_ack", 32'(entry_ack), 32'b01);
      entry_req = 2'b00;
      step();
      step();
      check("abort_gate_before", 32'(gate_open), 32'b01);
      reset = 1'b0;
      step();
      check("abort_gate",  32'(gate_open), 32'd0);
      check("abort_count", 32'(count), 32'd0);
      check("abort_empty", 32'(empty), 32'd1);
      check("abort_busy",  32'(busy), 32'd0);
`ifdef PARK_STATS_EN
      check("stats_rst_entries", 32'(entries_total), 32'd0);
      check("stats_rst_denies",  32'(denies_total),  32'd0);
`endif
      reset = 1'b1;
      step();
      check("post_abort_gate", 32'(gate_open), 32'd0);
      check("post_abort_busy", 32'(busy), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
